dwt53_h_lift: RTL
=================

Name: dwt53_h_lift

Overview:
- Streaming forward reversible 5/3 (Le Gall) horizontal lifting stage for the JPEG2000 DWT path.
- Consumes one raster line of signed samples per AXI-stream packet. Produces the same number of coefficients, interleaved L0,H0,L1,H1,…
- Sits directly upstream of the in-line reorder stage, which deinterleaves each line into low and high halves.
- No line buffering: only a two-sample window plus a small output buffer.

Parameters:
- DataWidth, 16, input sample width, signed two's complement. Output width is DataWidth+1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- in_tdata  input  DataWidth  input sample x[i], signed.
- in_tvalid  input  1  input beat valid.
- in_tready  output  1  input beat accepted when tvalid&tready.
- in_tlast  input  1  marks x[N-1], the last sample of a line.
- out_tdata  output  DataWidth+1  coefficient, signed.
- out_tvalid  output  1  output beat valid.
- out_tready  input  1  downstream ready.
- out_tlast  output  1  marks the last coefficient of a line.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: out_tvalid=0, out_tlast=0, out_tdata=0, in_tready=1. Line position is reset to "even, first of line"; the output buffer is emptied.
- Reset mid-line: the partial line is discarded with no output. The next accepted beat is x[0] of a new line.
- Lifting, all arithmetic signed, floor = arithmetic shift right:
  - d[k] = x[2k+1] - floor((x[2k]+x[2k+2])/2)
  - s[k] = x[2k] + floor((d[k-1]+d[k]+2)/4)
- Whole-sample symmetric extension:
  - x[N] = x[N-2], so for even N: d[N/2-1] = x[N-1] - x[N-2].
  - d[-1] = d[0].
  - Odd N: the missing final d is taken as d[last] = d[last-1].
- Intermediate sums are kept at DataWidth+2 bits; results are truncated to DataWidth+1.
- Emission order per pair: s[k] then d[k]. out_tlast is set on the final beat only.
- Completion points:
  - Pair k completes when x[2k+2] is accepted, or when x[2k+1] is accepted with tlast.
  - Odd N: the final s is emitted alone with tlast when x[N-1] is accepted with tlast.
- Line-length special cases:
  - N=1: out = sign-extended x[0], tlast=1.
  - N=2: out = s0, d0.
- Latency: the first beat of a completed pair is presented (out_tvalid=1) the cycle after the completing input is accepted.
- State machine:
  - EVEN0: expect x[0].
  - ODD: expect x[2k+1].
  - EVEN: expect x[2k+2].
  - Transitions:
    - EVEN0 →ODD on accept without tlast; stays in EVEN0 on accept with tlast (N=1).
    - ODD →EVEN without tlast; →EVEN0 with tlast.
    - EVEN →ODD without tlast; →EVEN0 with tlast.
  - Held registers: previous even sample, current odd sample, previous d, and a first-pair flag (selects the d[-1]=d[0] rule).
- Output buffer:
  - Holds at least one full pair plus one pending beat.
  - in_tready=0 only when accepting could overflow the buffer. A same-cycle pop counts as freeing space.
  - With out_tready held at 1, sustained throughput is 1 sample/cycle: no bubbles within a line or across line boundaries.
  - x[0] of the next line may be accepted in the same cycle the previous tlast pair is produced.
- AXI-stream rules:
  - out_tdata/out_tlast are stable while out_tvalid=1 and out_tready=0.
  - out_tvalid never drops without a handshake.
  - in_tready does not depend combinationally on in_tvalid.
- Beats out per line = beats in per line. One output tlast per input tlast.

Test Plan:
- Line [10,20,30,40], tlast on 40, out_tready=1 → out 10,0,33,10, tlast on 4th. 1 beat/cycle. First out_tvalid one cycle after x[2] accepted.
- Negatives [-3,-8,-1,0] → -6,-6,-2,1. Separately, [5,9] → 7,4. Line of length 1, [-7] → -7 with tlast.
- Odd length [1,2,3] → 1,0,3, tlast on 3. Follow immediately with [10,20,30,40] back-to-back → no bubble, correct second line.
- Random out_tready (50%), 100 lines of random length 1..64 with full-range random data → output matches the reference lifting model bit-exact. tdata/tlast stable under stall. Never more than one pair outstanding beyond the buffer depth.
- rst asserted after x[5] of a 16-sample line → next cycle out_tvalid=0 and in_tready=1. The next line [5,9] yields 7,4 with no residue from the aborted line.
- Continuous out_tready=1, 8 lines of 512 samples streamed back-to-back → in_tready never deasserts after the first line starts. 4096 outputs, 8 tlasts.

Source files
------------

// File: rtl/dwt53_h_lift.sv
// Streaming forward reversible 5/3 horizontal lifting, one line per packet.
// Emits interleaved s[k], d[k] using a two-sample window and a 4-entry output buffer.
module dwt53_h_lift #(
  parameter int DataWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DataWidth-1:0] in_tdata,
  input  logic                 in_tvalid,
  output logic                 in_tready,
  input  logic                 in_tlast,
  output logic [DataWidth:0]   out_tdata,
  output logic                 out_tvalid,
  input  logic                 out_tready,
  output logic                 out_tlast
);
  localparam int OW = DataWidth + 1;
  localparam int SW = DataWidth + 2;
  localparam int Depth = 4;
  localparam logic signed [SW-1:0] RoundTwo = SW'(2);

  typedef enum logic [1:0] {EVEN0, ODD, EVEN} state_t;

  state_t               state_q, state_d;
  logic [DataWidth-1:0] even_q, even_d;
  logic [DataWidth-1:0] odd_q, odd_d;
  logic [OW-1:0]        dprev_q, dprev_d;
  logic                 first_q, first_d;
  logic [OW-1:0]        buf_data_q [Depth];
  logic [OW-1:0]        buf_data_d [Depth];
  logic                 buf_last_q [Depth];
  logic                 buf_last_d [Depth];
  logic [1:0]           rd_ptr_q, rd_ptr_d;
  logic [2:0]           count_q, count_d;

  logic signed [SW-1:0] x_w, even_w, odd_w, right_w;
  logic signed [SW-1:0] dnew_w, dprev_w, dsum_w, dlast_w;
  logic [OW-1:0]        d_new, s_new, s_last;

  logic                 pop, accept;
  logic [1:0]           max_push, push_cnt, wr_base;
  logic [OW-1:0]        push_data [3];
  logic                 push_last [3];

  // In ODD the incoming sample is the final odd one of an even-length line, so its right neighbour mirrors to x[2k].
  always_comb begin
    x_w     = {{2{in_tdata[DataWidth-1]}}, in_tdata};
    even_w  = {{2{even_q[DataWidth-1]}}, even_q};
    odd_w   = (state_q == ODD) ? x_w : {{2{odd_q[DataWidth-1]}}, odd_q};
    right_w = (state_q == ODD) ? even_w : x_w;
    d_new   = OW'(odd_w - ((even_w + right_w) >>> 1));
    dnew_w  = {d_new[OW-1], d_new};
    dprev_w = first_q ? dnew_w : {dprev_q[OW-1], dprev_q};
    dsum_w  = dprev_w + dnew_w + RoundTwo;
    dlast_w = dnew_w + dnew_w + RoundTwo;
    s_new   = OW'(even_w + (dsum_w >>> 2));
    s_last  = OW'(x_w + (dlast_w >>> 2));
  end

  always_comb begin
    pop = (count_q != 3'd0) && out_tready;
    case (state_q)
      EVEN0:   max_push = 2'd1;
      ODD:     max_push = 2'd2;
      default: max_push = 2'd3;
    endcase
    in_tready = ({1'b0, count_q} - {3'b0, pop} + {2'b0, max_push}) <= 4'(Depth);
    accept    = in_tvalid && in_tready;

    state_d      = state_q;
    even_d       = even_q;
    odd_d        = odd_q;
    dprev_d      = dprev_q;
    first_d      = first_q;
    push_cnt     = 2'd0;
    push_data[0] = '0;
    push_data[1] = '0;
    push_data[2] = '0;
    push_last[0] = 1'b0;
    push_last[1] = 1'b0;
    push_last[2] = 1'b0;

    if (accept) begin
      case (state_q)
        EVEN0: begin
          even_d  = in_tdata;
          first_d = 1'b1;
          if (in_tlast) begin
            push_cnt     = 2'd1;
            push_data[0] = {in_tdata[DataWidth-1], in_tdata};
            push_last[0] = 1'b1;
          end else begin
            state_d = ODD;
          end
        end
        ODD: begin
          odd_d        = in_tdata;
          push_data[0] = s_new;
          push_data[1] = d_new;
          if (in_tlast) begin
            push_cnt     = 2'd2;
            push_last[1] = 1'b1;
            state_d      = EVEN0;
          end else begin
            state_d = EVEN;
          end
        end
        EVEN: begin
          even_d       = in_tdata;
          dprev_d      = d_new;
          first_d      = 1'b0;
          push_cnt     = 2'd2;
          push_data[0] = s_new;
          push_data[1] = d_new;
          state_d      = ODD;
          if (in_tlast) begin
            push_cnt     = 2'd3;
            push_data[2] = s_last;
            push_last[2] = 1'b1;
            state_d      = EVEN0;
          end
        end
        default: state_d = EVEN0;
      endcase
    end
  end

  // Circular buffer: up to three writes and one read per cycle.
  always_comb begin
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    wr_base    = rd_ptr_q + count_q[1:0];
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < push_cnt) begin
        buf_data_d[wr_base + 2'(i)] = push_data[i];
        buf_last_d[wr_base + 2'(i)] = push_last[i];
      end
    end
    rd_ptr_d = rd_ptr_q + {1'b0, pop};
    count_d  = count_q - {2'b0, pop} + {1'b0, push_cnt};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EVEN0;
      even_q   <= '0;
      odd_q    <= '0;
      dprev_q  <= '0;
      first_q  <= 1'b1;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) begin
        buf_data_q[i] <= '0;
        buf_last_q[i] <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      even_q     <= even_d;
      odd_q      <= odd_d;
      dprev_q    <= dprev_d;
      first_q    <= first_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      buf_data_q <= buf_data_d;
      buf_last_q <= buf_last_d;
    end
  end

  assign out_tvalid = (count_q != 3'd0);
  assign out_tdata  = buf_data_q[rd_ptr_q];
  assign out_tlast  = buf_last_q[rd_ptr_q] && out_tvalid;

endmodule
